// File: rtl/regfile_write_arbiter.sv
// Single write port of the register file: hardware clear sweep after reset, then round-robin between two writebacks.
// Latency: an accepted request appears on rfWrite/rfAddr/rfData in the cycle after the accepting edge.
// Backpressure: readies stay low while clearing; the losing requester holds its request until granted.
module regfile_write_arbiter #(
    parameter int WordLen   = 32,
    parameter int WordCount = 16,
    localparam int AW = (WordCount > 1) ? $clog2(WordCount) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0Valid,
    input  logic [AW-1:0]      req0Addr,
    input  logic [WordLen-1:0] req0Data,
    output logic               req0Ready,
    input  logic               req1Valid,
    input  logic [AW-1:0]      req1Addr,
    input  logic [WordLen-1:0] req1Data,
    output logic               req1Ready,
    output logic               rfWrite,
    output logic [AW-1:0]      rfAddr,
    output logic [WordLen-1:0] rfData,
    output logic               initDone
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(WordCount - 1);

    state_t               state_q, state_d;
    logic [AW-1:0]        clear_idx_q, clear_idx_d;
    logic                 last_grant_q, last_grant_d;
    logic                 rf_write_q, rf_write_d;
    logic [AW-1:0]        rf_addr_q, rf_addr_d;
    logic [WordLen-1:0]   rf_data_q, rf_data_d;
    logic                 init_done_q, init_done_d;

    logic                 grant_vld;
    logic                 grant_sel;

    // Grant looks only at the valids and the previous winner, never at address/data.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        if (state_q == RUN) begin
            if (req0Valid && req1Valid) begin
                grant_vld = 1'b1;
                grant_sel = ~last_grant_q;
            end else if (req0Valid) begin
                grant_vld = 1'b1;
                grant_sel = 1'b0;
            end else if (req1Valid) begin
                grant_vld = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    assign req0Ready = grant_vld && !grant_sel;
    assign req1Ready = grant_vld &&  grant_sel;

    always_comb begin
        state_d      = state_q;
        clear_idx_d  = clear_idx_q;
        last_grant_d = last_grant_q;
        rf_write_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_data_d    = rf_data_q;
        init_done_d  = init_done_q;

        case (state_q)
            CLEAR: begin
                rf_write_d  = 1'b1;
                rf_addr_d   = clear_idx_q;
                rf_data_d   = '0;
                clear_idx_d = clear_idx_q + AW'(1);
                if (clear_idx_q == LAST_IDX) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                // Address and data hold their last value on idle cycles.
                if (grant_vld) begin
                    rf_write_d   = 1'b1;
                    rf_addr_d    = grant_sel ? req1Addr : req0Addr;
                    rf_data_d    = grant_sel ? req1Data : req0Data;
                    last_grant_d = grant_sel;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clear_idx_q  <= '0;
            last_grant_q <= 1'b1;
            rf_write_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_idx_q  <= clear_idx_d;
            last_grant_q <= last_grant_d;
            rf_write_q   <= rf_write_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            init_done_q  <= init_done_d;
        end
    end

    assign rfWrite  = rf_write_q;
    assign rfAddr   = rf_addr_q;
    assign rfData   = rf_data_q;
    assign initDone = init_done_q;

endmodule
